// File: rtl/serial_subtractor_nbit.sv
// serial_subtractor_nbit: bit-serial N-bit subtractor, d = x - y - b_in.
// One full-subtractor cell is reused for N clocks, LSB first, with the ripple
// borrow held in a flop. start/busy/done handshake toward a controlling FSM.
// Optional feature macro: SERIAL_SUB_OVF_EN adds a registered signed-overflow
// output ovf, updated together with d/b_out.
module serial_subtractor_nbit #(
    parameter int N = 4
) (
    input  logic         clk,
    input  logic         rst_n,
    input  logic         start,
    input  logic [N-1:0] x,
    input  logic [N-1:0] y,
    input  logic         b_in,
    output logic         busy,
    output logic         done,
    output logic [N-1:0] d,
    output logic         b_out
`ifdef SERIAL_SUB_OVF_EN
    ,
    output logic         ovf
`endif
);

    localparam int CW = (N > 1) ? $clog2(N) : 1;
    localparam logic [CW-1:0] LAST = CW'(N - 1);

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        SHIFT = 2'd1,
        DONE  = 2'd2
    } state_t;

    state_t        state_q, state_d;
    logic [N-1:0]  xs_q, xs_d;
    logic [N-1:0]  ys_q, ys_d;
    logic [N-1:0]  rs_q, rs_d;
    logic          bor_q, bor_d;
    logic [CW-1:0] cnt_q, cnt_d;
    logic [N-1:0]  res_q, res_d;
    logic          bout_q, bout_d;
`ifdef SERIAL_SUB_OVF_EN
    logic          ovf_q, ovf_d;
`endif

    // Full-subtractor cell operating on the current LSBs and held borrow.
    logic          diff_bit;
    logic          bor_next;
    logic [N-1:0]  rs_shifted;

    // Single-bit difference and borrow-out of the shared subtractor cell.
    always_comb begin
        diff_bit   = xs_q[0] ^ ys_q[0] ^ bor_q;
        bor_next   = (~xs_q[0] & ys_q[0]) | (~(xs_q[0] ^ ys_q[0]) & bor_q);
        rs_shifted = {diff_bit, rs_q[N-1:1]};
    end

    // Next-state and datapath-update logic; defaults hold every register.
    always_comb begin
        state_d = state_q;
        xs_d    = xs_q;
        ys_d    = ys_q;
        rs_d    = rs_q;
        bor_d   = bor_q;
        cnt_d   = cnt_q;
        res_d   = res_q;
        bout_d  = bout_q;
`ifdef SERIAL_SUB_OVF_EN
        ovf_d   = ovf_q;
`endif
        unique case (state_q)
            IDLE: begin
                if (start) begin
                    xs_d    = x;
                    ys_d    = y;
                    bor_d   = b_in;
                    cnt_d   = '0;
                    state_d = SHIFT;
                end
            end
            SHIFT: begin
                xs_d  = xs_q >> 1;
                ys_d  = ys_q >> 1;
                bor_d = bor_next;
                rs_d  = rs_shifted;
                cnt_d = cnt_q + CW'(1);
                if (cnt_q == LAST) begin
                    // Publish the full word only on the last bit so d never shows partial results.
                    res_d   = rs_shifted;
                    bout_d  = bor_next;
`ifdef SERIAL_SUB_OVF_EN
                    // bor_q is the borrow into the MSB, bor_next the borrow out of it.
                    ovf_d   = bor_q ^ bor_next;
`endif
                    state_d = DONE;
                end
            end
            DONE: begin
                if (start) begin
                    xs_d    = x;
                    ys_d    = y;
                    bor_d   = b_in;
                    cnt_d   = '0;
                    state_d = SHIFT;
                end else begin
                    state_d = IDLE;
                end
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    // FSM state register.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    // Operand shifters, borrow flop, counter and registered results.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            xs_q   <= '0;
            ys_q   <= '0;
            rs_q   <= '0;
            bor_q  <= 1'b0;
            cnt_q  <= '0;
            res_q  <= '0;
            bout_q <= 1'b0;
`ifdef SERIAL_SUB_OVF_EN
            ovf_q  <= 1'b0;
`endif
        end else begin
            xs_q   <= xs_d;
            ys_q   <= ys_d;
            rs_q   <= rs_d;
            bor_q  <= bor_d;
            cnt_q  <= cnt_d;
            res_q  <= res_d;
            bout_q <= bout_d;
`ifdef SERIAL_SUB_OVF_EN
            ovf_q  <= ovf_d;
`endif
        end
    end

    // Outputs come straight from registers; no input-to-output path.
    always_comb begin
        busy  = (state_q == SHIFT);
        done  = (state_q == DONE);
        d     = res_q;
        b_out = bout_q;
`ifdef SERIAL_SUB_OVF_EN
        ovf   = ovf_q;
`endif
    end

endmodule

// File: tb/tb_serial_subtractor_nbit.sv
// Self-checking bench for serial_subtractor_nbit (N=4). Expected results are
// computed by a word-level model, queued at start, and popped on done.
module tb_serial_subtractor_nbit;

    localparam int N = 4;

    typedef struct packed {
        logic [N-1:0] d;
        logic         b;
        logic         o;
    } exp_t;

    logic         clk;
    logic         rst_n;
    logic         start;
    logic [N-1:0] x;
    logic [N-1:0] y;
    logic         b_in;
    logic         busy;
    logic         done;
    logic [N-1:0] d;
    logic         b_out;
`ifdef SERIAL_SUB_OVF_EN
    logic         ovf;
`endif

    int   checks = 0;
    int   errors = 0;
    exp_t sb[$];
    logic [N-1:0] last_d = '0;
    logic         last_b = 1'b0;

    serial_subtractor_nbit #(.N(N)) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .start (start),
        .x     (x),
        .y     (y),
        .b_in  (b_in),
        .busy  (busy),
        .done  (done),
        .d     (d),
        .b_out (b_out)
`ifdef SERIAL_SUB_OVF_EN
        ,
        .ovf   (ovf)
`endif
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    function automatic exp_t model(input logic [N-1:0] a, input logic [N-1:0] s, input logic c);
        logic [N:0] r;
        exp_t e;
        r   = {1'b0, a} - {1'b0, s} - {{N{1'b0}}, c};
        e.d = r[N-1:0];
        e.b = r[N];
        e.o = (a[N-1] != s[N-1]) && (r[N-1] != a[N-1]);
        return e;
    endfunction

    task automatic test_reset();
        rst_n = 1'b0;
        start = 1'b0;
        x     = '0;
        y     = '0;
        b_in  = 1'b0;
        #1;
        checks++;
        if (busy !== 1'b0) begin errors++; $display("FAIL reset_busy got %0b exp 0", busy); end
        checks++;
        if (done !== 1'b0) begin errors++; $display("FAIL reset_done got %0b exp 0", done); end
        checks++;
        if (d !== '0) begin errors++; $display("FAIL reset_d got %0d exp 0", d); end
        checks++;
        if (b_out !== 1'b0) begin errors++; $display("FAIL reset_bout got %0b exp 0", b_out); end
`ifdef SERIAL_SUB_OVF_EN
        checks++;
        if (ovf !== 1'b0) begin errors++; $display("FAIL reset_ovf got %0b exp 0", ovf); end
`endif
        @(negedge clk);
        @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);
    endtask

    task automatic test_basic();
        logic [N-1:0] vx[7] = '{4'd9, 4'd3, 4'd0, 4'd15, 4'd0, 4'd8, 4'd7};
        logic [N-1:0] vy[7] = '{4'd3, 4'd9, 4'd0, 4'd15, 4'd15, 4'd1, 4'd1};
        logic         vb[7] = '{1'b0, 1'b0, 1'b1, 1'b0, 1'b1, 1'b0, 1'b0};
        for (int i = 0; i < 15; i++) begin
            logic [N-1:0] a, s;
            logic         c;
            logic [31:0]  r;
            exp_t         e, got;
            int           cyc, nbusy;
            bit           hold_ok;
            if (i < 7) begin
                a = vx[i]; s = vy[i]; c = vb[i];
            end else begin
                r = $urandom; a = r[N-1:0]; s = r[N+3:4]; c = r[8];
            end
            sb.push_back(model(a, s, c));
            @(negedge clk);
            start = 1'b1; x = a; y = s; b_in = c;
            @(negedge clk);
            start = 1'b0;
            r = $urandom; x = r[N-1:0]; y = r[N+3:4]; b_in = r[9];
            cyc = 1;
            nbusy = (busy === 1'b1) ? 1 : 0;
            hold_ok = (d === last_d) && (b_out === last_b);
            while (done !== 1'b1 && cyc < 4 * N) begin
                @(negedge clk);
                cyc++;
                if (busy === 1'b1) nbusy++;
                if (done !== 1'b1 && (d !== last_d || b_out !== last_b)) hold_ok = 1'b0;
            end
            checks++;
            if (cyc != N + 1) begin errors++; $display("FAIL latency op%0d got %0d exp %0d", i, cyc, N + 1); end
            checks++;
            if (nbusy != N) begin errors++; $display("FAIL busy_len op%0d got %0d exp %0d", i, nbusy, N); end
            checks++;
            if (!hold_ok) begin errors++; $display("FAIL hold op%0d d/b_out changed before done (prev %0d/%0b)", i, last_d, last_b); end
            checks++;
            if (busy !== 1'b0) begin errors++; $display("FAIL busy_at_done op%0d got %0b exp 0", i, busy); end
            if (sb.size() == 0) begin
                checks++; errors++;
                $display("FAIL scoreboard op%0d empty", i);
            end else begin
                e = sb.pop_front();
                got.d = d; got.b = b_out; got.o = e.o;
`ifdef SERIAL_SUB_OVF_EN
                got.o = ovf;
`endif
                checks++;
                if (got !== e) begin
                    errors++;
                    $display("FAIL result op%0d x=%0d y=%0d b=%0b got d=%0d b=%0b o=%0b exp d=%0d b=%0b o=%0b",
                             i, a, s, c, got.d, got.b, got.o, e.d, e.b, e.o);
                end
                last_d = e.d; last_b = e.b;
            end
            @(negedge clk);
            checks++;
            if (done !== 1'b0 || busy !== 1'b0) begin
                errors++;
                $display("FAIL done_pulse op%0d got done=%0b busy=%0b exp 0/0", i, done, busy);
            end
        end
    endtask

    task automatic test_back_to_back();
        exp_t e;
        int   cyc;
        sb.push_back(model(4'd12, 4'd5, 1'b1));
        @(negedge clk);
        start = 1'b1; x = 4'd12; y = 4'd5; b_in = 1'b1;
        @(negedge clk);
        // start stays high; these operands must only be taken at the DONE edge
        x = 4'd2; y = 4'd7; b_in = 1'b0;
        sb.push_back(model(4'd2, 4'd7, 1'b0));
        cyc = 1;
        while (done !== 1'b1 && cyc < 4 * N) begin @(negedge clk); cyc++; end
        checks++;
        if (cyc != N + 1) begin errors++; $display("FAIL b2b_first_latency got %0d exp %0d", cyc, N + 1); end
        e = sb.pop_front();
        checks++;
        if (d !== e.d || b_out !== e.b) begin
            errors++; $display("FAIL b2b_first got d=%0d b=%0b exp d=%0d b=%0b", d, b_out, e.d, e.b);
        end
        @(negedge clk);
        start = 1'b0;
        checks++;
        if (busy !== 1'b1) begin errors++; $display("FAIL b2b_no_idle busy got %0b exp 1", busy); end
        cyc = 1;
        while (done !== 1'b1 && cyc < 4 * N) begin @(negedge clk); cyc++; end
        checks++;
        if (cyc != N + 1) begin errors++; $display("FAIL b2b_spacing got %0d exp %0d", cyc, N + 1); end
        e = sb.pop_front();
        checks++;
        if (d !== e.d || b_out !== e.b) begin
            errors++; $display("FAIL b2b_second got d=%0d b=%0b exp d=%0d b=%0b", d, b_out, e.d, e.b);
        end
        last_d = e.d; last_b = e.b;
        @(negedge clk);
    endtask

    task automatic test_ignore_start();
        exp_t e;
        int   cyc;
        bit   extra;
        sb.push_back(model(4'd5, 4'd2, 1'b0));
        @(negedge clk);
        start = 1'b1; x = 4'd5; y = 4'd2; b_in = 1'b0;
        @(negedge clk);
        start = 1'b0;
        @(negedge clk);
        start = 1'b1; x = 4'd1; y = 4'd9; b_in = 1'b1;
        @(negedge clk);
        start = 1'b0;
        cyc = 3;
        while (done !== 1'b1 && cyc < 4 * N) begin @(negedge clk); cyc++; end
        checks++;
        if (cyc != N + 1) begin errors++; $display("FAIL ignore_latency got %0d exp %0d", cyc, N + 1); end
        e = sb.pop_front();
        checks++;
        if (d !== e.d || b_out !== e.b) begin
            errors++; $display("FAIL ignore_result got d=%0d b=%0b exp d=%0d b=%0b", d, b_out, e.d, e.b);
        end
        last_d = e.d; last_b = e.b;
        extra = 1'b0;
        for (int k = 0; k < 2 * N + 2; k++) begin
            @(negedge clk);
            if (done === 1'b1 || busy === 1'b1) extra = 1'b1;
        end
        checks++;
        if (extra) begin errors++; $display("FAIL ignore_queued got extra activity exp none"); end
    endtask

    task automatic test_reset_midop();
        exp_t e;
        int   cyc;
        bit   spurious;
        @(negedge clk);
        start = 1'b1; x = 4'd10; y = 4'd4; b_in = 1'b0;
        @(negedge clk);
        start = 1'b0;
        @(negedge clk);
        @(negedge clk);
        rst_n = 1'b0;
        #1;
        checks++;
        if (busy !== 1'b0 || done !== 1'b0) begin
            errors++; $display("FAIL midrst_ctrl got busy=%0b done=%0b exp 0/0", busy, done);
        end
        checks++;
        if (d !== '0 || b_out !== 1'b0) begin
            errors++; $display("FAIL midrst_out got d=%0d b=%0b exp 0/0", d, b_out);
        end
        @(negedge clk);
        rst_n = 1'b1;
        last_d = '0; last_b = 1'b0;
        spurious = 1'b0;
        for (int k = 0; k < 2 * N + 2; k++) begin
            @(negedge clk);
            if (done === 1'b1) spurious = 1'b1;
        end
        checks++;
        if (spurious) begin errors++; $display("FAIL midrst_done got pulse exp none"); end
        sb.push_back(model(4'd6, 4'd6, 1'b1));
        @(negedge clk);
        start = 1'b1; x = 4'd6; y = 4'd6; b_in = 1'b1;
        @(negedge clk);
        start = 1'b0;
        cyc = 1;
        while (done !== 1'b1 && cyc < 4 * N) begin @(negedge clk); cyc++; end
        checks++;
        if (cyc != N + 1) begin errors++; $display("FAIL midrst_next_latency got %0d exp %0d", cyc, N + 1); end
        e = sb.pop_front();
        checks++;
        if (d !== e.d || b_out !== e.b) begin
            errors++; $display("FAIL midrst_next got d=%0d b=%0b exp d=%0d b=%0b", d, b_out, e.d, e.b);
        end
        @(negedge clk);
    endtask

    initial begin
        test_reset();
        test_basic();
        test_back_to_back();
        test_ignore_start();
        test_reset_midop();
        checks++;
        if (sb.size() != 0) begin errors++; $display("FAIL scoreboard_leftover got %0d exp 0", sb.size()); end
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
